// File: rtl/lcd_pkg.sv
// Shared encodings and default timing constants for the LCD panel power sequencer.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_PWR_WAIT  = 3'd1,
    ST_TIMING_ON = 3'd2,
    ST_DISP_ON   = 3'd3,
    ST_RUN       = 3'd4,
    ST_BL_OFF    = 3'd5,
    ST_DISP_OFF  = 3'd6
  } lcd_state_e;

  typedef struct packed {
    logic lcd_pwr_en;
    logic timing_rst;
    logic lcd_disp;
    logic bl_en;
  } lcd_rails_t;

  localparam logic [15:0] PWR_DLY_DEF     = 16'd3300;
  localparam logic [7:0]  DISP_FRAMES_DEF = 8'd2;
  localparam logic [7:0]  BL_FRAMES_DEF   = 8'd5;
  localparam logic [7:0]  OFF_FRAMES_DEF  = 8'd2;
  localparam logic [23:0] FRAME_TO_DEF    = 24'd1_200_000;

  // Panel rail levels held while the sequencer sits in a given state.
  function automatic lcd_rails_t rails_for(lcd_state_e s);
    lcd_rails_t r;
    r.lcd_pwr_en = (s != ST_OFF);
    r.timing_rst = (s == ST_OFF) || (s == ST_PWR_WAIT) || (s == ST_DISP_OFF);
    r.lcd_disp   = (s == ST_DISP_ON) || (s == ST_RUN) || (s == ST_BL_OFF);
    r.bl_en      = (s == ST_RUN);
    return r;
  endfunction

endpackage

// File: rtl/lcd_power_sequencer_if.sv
// Signal bundle between the power sequencer and its host / panel side.
interface lcd_power_sequencer_if;
  // pwr_req is a level request; ready is high exactly while the panel is fully
  // up (RUN). Dropping pwr_req starts an ordered power-down; ready falls at once.
  logic       pwr_req;
  logic       vs;
  logic [7:0] brightness;
  logic       lcd_pwr_en;
  logic       timing_rst;
  logic       lcd_disp;
  logic       bl_en;
  logic       bl_pwm;
  logic       ready;
  logic       fault;
  logic [2:0] state;

  modport master (
    input  pwr_req, vs, brightness,
    output lcd_pwr_en, timing_rst, lcd_disp, bl_en, bl_pwm, ready, fault, state
  );

  modport slave (
    output pwr_req, vs, brightness,
    input  lcd_pwr_en, timing_rst, lcd_disp, bl_en, bl_pwm, ready, fault, state
  );
endinterface

// File: rtl/lcd_bl_pwm.sv
// Backlight PWM: free-running 8-bit period, duty latched only at period end.
module lcd_bl_pwm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] brightness,
  output logic       pwm
);

  logic [7:0] pwm_cnt;
  logic [7:0] duty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= 8'd0;
      duty    <= 8'd0;
      pwm     <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      // Loading only on the last count keeps every period at a single duty.
      if (pwm_cnt == 8'hFF) duty <= brightness;
      pwm <= en & (pwm_cnt < duty);
    end
  end

endmodule

// File: rtl/lcd_power_sequencer.sv
// LCD panel power sequencer: ordered VDD / timing / DISP / backlight bring-up
// and tear-down, paced by frame ticks and guarded by a frame watchdog.
module lcd_power_sequencer
  import lcd_pkg::*;
#(
  parameter logic [15:0] PWR_DLY     = PWR_DLY_DEF,
  parameter logic [7:0]  DISP_FRAMES = DISP_FRAMES_DEF,
  parameter logic [7:0]  BL_FRAMES   = BL_FRAMES_DEF,
  parameter logic [7:0]  OFF_FRAMES  = OFF_FRAMES_DEF,
  parameter logic [23:0] FRAME_TO    = FRAME_TO_DEF
) (
  input logic                   clk,
  input logic                   rst_n,
  lcd_power_sequencer_if.master bus
);

  lcd_state_e  state_q, state_d;
  lcd_rails_t  rails_q, rails_d;
  logic        vs_d;
  logic        tick;
  logic        in_frames;
  logic        state_change;
  logic        dly_done;
  logic        timeout;
  logic        ready_q;
  logic        fault_q;
  logic [15:0] dly_cnt;
  logic [7:0]  frame_cnt;
  logic [23:0] wdog_cnt;

  assign tick         = vs_d & ~bus.vs;
  assign in_frames    = (state_q == ST_TIMING_ON) || (state_q == ST_DISP_ON) ||
                        (state_q == ST_BL_OFF);
  assign dly_done     = (dly_cnt == PWR_DLY - 16'd1);
  assign timeout      = in_frames && !tick && (wdog_cnt == FRAME_TO - 24'd1);
  assign state_change = (state_d != state_q);
  assign rails_d      = rails_for(state_d);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF:       if (bus.pwr_req) state_d = ST_PWR_WAIT;
      ST_PWR_WAIT: begin
        if (!bus.pwr_req)  state_d = ST_OFF;
        else if (dly_done) state_d = ST_TIMING_ON;
      end
      ST_TIMING_ON: begin
        if (!bus.pwr_req || timeout)                      state_d = ST_DISP_OFF;
        else if (tick && frame_cnt == DISP_FRAMES - 8'd1) state_d = ST_DISP_ON;
      end
      ST_DISP_ON: begin
        if (!bus.pwr_req || timeout)                    state_d = ST_DISP_OFF;
        else if (tick && frame_cnt == BL_FRAMES - 8'd1) state_d = ST_RUN;
      end
      ST_RUN:       if (!bus.pwr_req) state_d = ST_BL_OFF;
      // Requests are ignored on the way down; OFF re-sequences if still asked.
      ST_BL_OFF: begin
        if (timeout)                                         state_d = ST_DISP_OFF;
        else if (tick && frame_cnt == OFF_FRAMES - 8'd1)     state_d = ST_DISP_OFF;
      end
      ST_DISP_OFF:  if (dly_done) state_d = ST_OFF;
      default:      state_d = ST_OFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
      rails_q <= rails_for(ST_OFF);
      ready_q <= 1'b0;
      fault_q <= 1'b0;
      vs_d    <= 1'b1;
    end else begin
      state_q <= state_d;
      rails_q <= rails_d;
      ready_q <= (state_d == ST_RUN);
      vs_d    <= bus.vs;
      if (state_change && state_d == ST_PWR_WAIT) fault_q <= 1'b0;
      else if (timeout)                           fault_q <= 1'b1;
    end
  end

  // Counters restart on every state change, so a tick that causes one is not carried over.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_cnt   <= 16'd0;
      frame_cnt <= 8'd0;
      wdog_cnt  <= 24'd0;
    end else if (state_change) begin
      dly_cnt   <= 16'd0;
      frame_cnt <= 8'd0;
      wdog_cnt  <= 24'd0;
    end else begin
      if (state_q == ST_PWR_WAIT || state_q == ST_DISP_OFF) dly_cnt <= dly_cnt + 16'd1;
      else                                                  dly_cnt <= 16'd0;
      if (in_frames && tick) frame_cnt <= frame_cnt + 8'd1;
      if (!in_frames || tick) wdog_cnt <= 24'd0;
      else                    wdog_cnt <= wdog_cnt + 24'd1;
    end
  end

  lcd_bl_pwm u_bl_pwm (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (rails_d.bl_en),
    .brightness (bus.brightness),
    .pwm        (bus.bl_pwm)
  );

  assign bus.lcd_pwr_en = rails_q.lcd_pwr_en;
  assign bus.timing_rst = rails_q.timing_rst;
  assign bus.lcd_disp   = rails_q.lcd_disp;
  assign bus.bl_en      = rails_q.bl_en;
  assign bus.ready      = ready_q;
  assign bus.fault      = fault_q;
  assign bus.state      = state_q;

endmodule
